// File: rtl/rr_index_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rr_index_encoder_pkg : shared sizes and FSM encoding for the write-port arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_index_encoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  // One bit is enough: IDLE == !out_valid, HOLD == out_valid.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : rr_index_encoder_pkg

`default_nettype wire

// File: rtl/rr_index_encoder_pick.sv
// ---------------------------------------------------------------------------
// rr_index_encoder_pick : round-robin search of req starting at ptr (combinational)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_index_encoder_pick
  import rr_index_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_o
);

  logic [2*N_REQ-1:0] dbl_w;
  logic [N_REQ-1:0]   rot_w;
  logic [IDX_W-1:0]   lsb_w;

  always_comb begin
    // Rotate right by ptr so bit ptr lands at position 0, then take the lowest set bit.
    dbl_w = {req_i, req_i} >> ptr_i;
    rot_w = dbl_w[N_REQ-1:0];
    lsb_w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_w[i]) lsb_w = IDX_W'(i);
    end
    // N_REQ is a power of two, so the IDX_W-bit add wraps modulo N_REQ.
    idx_o   = lsb_w + ptr_i;
    found_o = |req_i;
    multi_o = |(req_i & (req_i - N_REQ'(1)));
  end

endmodule : rr_index_encoder_pick

`default_nettype wire

// File: rtl/rr_index_encoder.sv
// ---------------------------------------------------------------------------
// rr_index_encoder : 8-way round-robin requester arbiter with valid/ready index output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_index_encoder
  import rr_index_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  input  logic             out_ready_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             multi_o,
  output logic [CNT_W-1:0] gnt_cnt_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             multi_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             found_w;
  logic [IDX_W-1:0] pick_idx_w;
  logic             pick_multi_w;
  logic             start_w;
  logic             hs_w;

  rr_index_encoder_pick u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (found_w),
    .idx_o   (pick_idx_w),
    .multi_o (pick_multi_w)
  );

  assign start_w = (state_q == ST_IDLE) && en_i && found_w;
  assign hs_w    = (state_q == ST_HOLD) && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_w) state_d = ST_HOLD;
      ST_HOLD: if (hs_w)    state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == ST_HOLD);
    out_idx_o   = idx_q;
    multi_o     = multi_q;
    gnt_cnt_o   = cnt_q;
  end

  // Grant is a decode of the held index, gated by the handshake cycle only.
  for (genvar g = 0; g < N_REQ; g++) begin : g_grant
    assign grant_o[g] = hs_w && (idx_q == IDX_W'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (start_w) begin
        idx_q   <= pick_idx_w;
        multi_q <= pick_multi_w;
      end
      if (hs_w) begin
        ptr_q <= idx_q + IDX_W'(1);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : rr_index_encoder

`default_nettype wire

// File: tb/tb_rr_index_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_index_encoder : directed self-checking bench, counter built 4 bits wide
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_index_encoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             en_i;
  logic [7:0]       req_i;
  logic             out_valid_o;
  logic [2:0]       out_idx_o;
  logic             out_ready_i;
  logic [7:0]       grant_o;
  logic             multi_o;
  logic [CNT_W-1:0] gnt_cnt_o;

  int n_cmp;
  int n_mis;

  rr_index_encoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .req_i       (req_i),
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .multi_o     (multi_o),
    .gnt_cnt_o   (gnt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Full select + handshake of requester 0 with out_ready held high.
  task automatic one_grant();
    en_i = 1'b1; req_i = 8'h01; out_ready_i = 1'b1;
    nedge();
    req_i = 8'h00;
    nedge();
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0; en_i = 1'b1; req_i = 8'hFF; out_ready_i = 1'b1;

    // 1: reset with every request active
    nedge(); nedge();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_idx",   32'(out_idx_o),   32'd0);
    chk("rst_grant", 32'(grant_o),     32'd0);
    chk("rst_cnt",   32'(gnt_cnt_o),   32'd0);
    chk("rst_multi", 32'(multi_o),     32'd0);
    req_i = 8'h00; out_ready_i = 1'b0;
    rst_n = 1'b1;
    nedge();
    chk("idle_valid", 32'(out_valid_o), 32'd0);

    // 2: single request
    en_i = 1'b1; req_i = 8'h20;
    nedge();
    chk("s_valid", 32'(out_valid_o), 32'd1);
    chk("s_idx",   32'(out_idx_o),   32'd5);
    chk("s_multi", 32'(multi_o),     32'd0);
    chk("s_nogrant", 32'(grant_o),   32'd0);
    req_i = 8'h00; out_ready_i = 1'b1;
    #1;
    chk("s_grant", 32'(grant_o), 32'h20);
    nedge();
    chk("s_done_valid", 32'(out_valid_o), 32'd0);
    chk("s_cnt",        32'(gnt_cnt_o),   32'd1);
    chk("idle_ready_nogrant", 32'(grant_o), 32'd0);
    // ptr=6: search 6,7,0 -> requester 0 beats 5
    req_i = 8'h21;
    nedge();
    chk("ptr6_idx",   32'(out_idx_o), 32'd0);
    chk("ptr6_multi", 32'(multi_o),   32'd1);
    chk("ptr6_grant", 32'(grant_o),   32'h01);
    req_i = 8'h00;
    nedge();
    chk("ptr6_cnt", 32'(gnt_cnt_o), 32'd2);

    // 3: round robin between 0 and 7, starting with ptr=1
    for (int k = 0; k < 4; k++) begin
      logic [2:0] e;
      e = (k % 2 == 0) ? 3'd7 : 3'd0;
      req_i = 8'h81; out_ready_i = 1'b1;
      nedge();
      chk("rr_valid", 32'(out_valid_o), 32'd1);
      chk("rr_idx",   32'(out_idx_o),   32'(e));
      chk("rr_multi", 32'(multi_o),     32'd1);
      chk("rr_grant", 32'(grant_o),     32'd1 << e);
      req_i = 8'h00;
      nedge();
      chk("rr_idle", 32'(out_valid_o), 32'd0);
    end
    chk("rr_cnt", 32'(gnt_cnt_o), 32'd6);

    // 4: backpressure (ptr=1)
    en_i = 1'b1; req_i = 8'h08; out_ready_i = 1'b0;
    nedge();
    req_i = 8'h00; en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_idx",   32'(out_idx_o),   32'd3);
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_grant", 32'(grant_o),     32'd0);
      nedge();
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_grant_hs", 32'(grant_o), 32'h08);
    nedge();
    chk("bp_cnt", 32'(gnt_cnt_o), 32'd7);

    // 5: reset mid-HOLD (ptr=4 before reset)
    en_i = 1'b1; req_i = 8'h10; out_ready_i = 1'b0;
    nedge();
    chk("mr_idx", 32'(out_idx_o), 32'd4);
    #2 rst_n = 1'b0; out_ready_i = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid_o), 32'd0);
    chk("mr_grant", 32'(grant_o),     32'd0);
    chk("mr_cnt",   32'(gnt_cnt_o),   32'd0);
    req_i = 8'h00; out_ready_i = 1'b0;
    nedge();
    rst_n = 1'b1; req_i = 8'h12;
    nedge();
    chk("mr_ptr0_idx", 32'(out_idx_o), 32'd1);
    out_ready_i = 1'b1; req_i = 8'h00;
    nedge();
    req_i = 8'h10; out_ready_i = 1'b0;
    nedge();
    chk("mr_idx4",   32'(out_idx_o),   32'd4);
    chk("mr_valid4", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b1; req_i = 8'h00;
    nedge();
    chk("mr_cnt2", 32'(gnt_cnt_o), 32'd2);

    // 6: enable gating, then counter wrap
    en_i = 1'b0; req_i = 8'hFF; out_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nedge();
      chk("en_gate", 32'(out_valid_o), 32'd0);
    end
    for (int k = 0; k < 13; k++) one_grant();
    chk("cnt_max", 32'(gnt_cnt_o), 32'd15);
    one_grant();
    chk("cnt_wrap", 32'(gnt_cnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_rr_index_encoder

`default_nettype wire
